// File: rtl/contador_gray.sv
// contador_gray: synchronous up/down binary counter with a registered
// Gray-code view of the count and a one-cycle wrap pulse.
//
// The binary count is the true state. The Gray word is always re-encoded
// from the next binary value, never stepped from the previous Gray word, so
// bin and gray can never drift apart and always change on the same edge.
//
// Priority on each rising edge: reset > load > en > hold.
// wrap pulses for one cycle after a step that crosses the modulus boundary:
//   - up from all ones to zero, or
//   - down from zero to all ones.
// A load never produces a wrap pulse, even when en is also high.
module contador_gray #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  // Registered state
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  // Next-state values
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = &r_bin;
  assign w_at_zero = ~|r_bin;

  // Next binary value and wrap flag; a load wins over a step
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next  = load_bin;
      w_wrap_next = 1'b0;
    end else if (en) begin
      if (up) begin
        w_bin_next  = r_bin + WIDTH'(1);
        w_wrap_next = w_at_max;
      end else begin
        w_bin_next  = r_bin - WIDTH'(1);
        w_wrap_next = w_at_zero;
      end
    end
  end

  // Gray encoding of the next binary value (logical shift keeps MSBs equal)
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_contador_gray.sv
// tb_contador_gray: directed bench for contador_gray (WIDTH=8) plus a
// model-tracked up/down sweep with direction flips.
module tb_contador_gray;

  localparam int W = 8;

  // Clock and DUT signals
  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_gray #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  // One rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] eb, input logic [W-1:0] eg,
                      input logic ew);
    chk({tag, ".bin"},  bin,  eb);
    chk({tag, ".gray"}, gray, eg);
    chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
  endtask

  logic [W-1:0] up_gray_tbl [6];
  logic [W-1:0] m_bin;
  logic [W-1:0] m_gray;
  logic         m_wrap;
  logic [W-1:0] prev_gray;
  int           m_wraps;
  int           d_wraps;

  initial begin
    up_gray_tbl[0] = 8'h01; up_gray_tbl[1] = 8'h03; up_gray_tbl[2] = 8'h02;
    up_gray_tbl[3] = 8'h06; up_gray_tbl[4] = 8'h07; up_gray_tbl[5] = 8'h05;

    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    step();
    chk3("reset", 8'h00, 8'h00, 1'b0);

    // Count up six steps from zero
    reset = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk3($sformatf("up%0d", i + 1), W'(i + 1), up_gray_tbl[i], 1'b0);
    end

    // Load all ones, then wrap upward
    load = 1'b1; load_bin = 8'hFF; en = 1'b0;
    step();
    chk3("load_ff", 8'hFF, 8'h80, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk3("wrap_up", 8'h00, 8'h00, 1'b1);
    step();
    chk3("after_wrap_up", 8'h01, 8'h01, 1'b0);

    // Down from zero after reset
    reset = 1'b1;
    step();
    chk3("reset2", 8'h00, 8'h00, 1'b0);
    reset = 1'b0; en = 1'b1; up = 1'b0;
    step();
    chk3("wrap_down", 8'hFF, 8'h80, 1'b1);
    step();
    chk3("after_wrap_down", 8'hFE, 8'h81, 1'b0);

    // Load beats enable, then hold for three cycles
    load = 1'b1; en = 1'b1; up = 1'b1; load_bin = 8'h2A;
    step();
    chk3("load_prio", 8'h2A, 8'h3F, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3($sformatf("hold%0d", i), 8'h2A, 8'h3F, 1'b0);
    end

    // Load at all ones with en/up high: no wrap
    load = 1'b1; load_bin = 8'hFF; en = 1'b0;
    step();
    load = 1'b1; load_bin = 8'hFF; en = 1'b1; up = 1'b1;
    step();
    chk3("load_at_max", 8'hFF, 8'h80, 1'b0);

    // Back-to-back wraps alternating across zero
    load = 1'b1; load_bin = 8'h00; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    chk3("bb_wrap0", 8'hFF, 8'h80, 1'b1);
    up = 1'b1;
    step();
    chk3("bb_wrap1", 8'h00, 8'h00, 1'b1);
    up = 1'b0;
    step();
    chk3("bb_wrap2", 8'hFF, 8'h80, 1'b1);

    // Reset mid-count overrides load and enable
    load = 1'b1; load_bin = 8'h57; en = 1'b0;
    step();
    chk3("load_57", 8'h57, 8'h7C, 1'b0);
    reset = 1'b1; load = 1'b1; load_bin = 8'h11; en = 1'b1; up = 1'b1;
    step();
    chk3("reset_mid", 8'h00, 8'h00, 1'b0);
    reset = 1'b0; load = 1'b0;
    step();
    chk3("resume", 8'h01, 8'h01, 1'b0);

    // Sweep: mostly up then mostly down, tracked by a model
    load = 1'b1; load_bin = 8'h80; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    m_bin = 8'h80; m_wraps = 0; d_wraps = 0; prev_gray = gray;
    for (int i = 0; i < 512; i++) begin
      if (i < 256) up = ($urandom_range(0, 9) != 0);
      else         up = ($urandom_range(0, 9) == 0);
      if (up) begin
        m_wrap = (m_bin == 8'hFF);
        m_bin  = m_bin + 8'd1;
      end else begin
        m_wrap = (m_bin == 8'h00);
        m_bin  = m_bin - 8'd1;
      end
      m_gray = m_bin ^ (m_bin >> 1);
      if (m_wrap) m_wraps++;
      step();
      if (wrap) d_wraps++;
      chk3($sformatf("sweep%0d", i), m_bin, m_gray, m_wrap);
      chk($sformatf("sweep%0d.inv", i), gray, bin ^ (bin >> 1));
      chk($sformatf("sweep%0d.onebit", i), W'($countones(prev_gray ^ gray)), 8'd1);
      prev_gray = gray;
    end
    chk("wrap_count", W'(d_wraps), W'(m_wraps));

    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_gray.md
# contador_gray

Synchronous up/down counter that keeps a binary count and presents it as a registered Gray-code word; it is the encode (binary→Gray) direction for the team's Gray-decode logic. Typical use: pointer generation for clock-domain-crossing FIFOs and position encoders, where consecutive outputs must differ in exactly one bit. Supports parallel load of a binary value, count enable, direction select and a one-cycle wrap indication.

## Interface
- WIDTH, 8, counter and output width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement (sampled only when stepping)
- load  input  1  synchronous parallel load of load_bin
- load_bin  input  WIDTH  binary value to load
- bin  output  WIDTH  registered binary count
- gray  output  WIDTH  registered Gray code of bin
- wrap  output  1  one-cycle pulse: the last step crossed the modulus boundary

## Operation
- Single clock domain, no combinational input→output paths; all outputs are flops.
- Priority per rising edge: reset > load > en > hold.
- reset=1: bin←0, gray←0, wrap←0.
- load=1 (reset=0): bin←load_bin, gray←load_bin ^ (load_bin >> 1), wrap←0; en and up ignored that cycle.
- en=1, up=1: bin←(bin+1) mod 2^WIDTH; wrap←1 iff old bin = all ones, else 0.
- en=1, up=0: bin←(bin−1) mod 2^WIDTH; wrap←1 iff old bin = 0, else 0.
- en=0, load=0: bin, gray hold; wrap←0.
- gray is computed from the next binary value, not from the current gray output: gray_next = bin_next ^ (bin_next >> 1) (logical shift, MSB of gray = MSB of bin). Invariant every cycle: gray == bin ^ (bin >> 1).
- Arithmetic is unsigned, WIDTH bits, wrap-around modulo 2^WIDTH; no saturation, no carry output besides wrap.
- Direction may change on any cycle; each step still changes gray in exactly one bit.

## Timing
- Latency: 1 cycle from a sampled reset/load/en to updated bin/gray/wrap.
- bin and gray always update on the same edge; never skewed by a cycle.
- wrap is high for exactly one cycle following the wrapping step; back-to-back wraps (e.g. alternating up/down across 0) give consecutive wrap pulses.
- Reset mid-count: next edge forces bin=gray=0, wrap=0 regardless of load/en; counting resumes from 0 the cycle after reset deasserts.
- load and en high together: load wins, no step, wrap=0.
- Load while at all-ones with en=1, up=1: no wrap pulse (load has priority).
- Between successive enabled steps (no load/reset), popcount(gray_old ^ gray_new) == 1 exactly.

## Test plan
- Reset then en=1, up=1 for 6 cycles (WIDTH=8) -> bin 1..6, gray 0x01,0x03,0x02,0x06,0x07,0x05; wrap=0 throughout.
- load=1, load_bin=0xFF, then en=1, up=1 -> gray 0x80 after load; next cycle bin=0x00, gray=0x00, wrap=1 for one cycle, then 0 on the following step.
- From reset (bin=0) en=1, up=0 -> bin=0xFF, gray=0x80, wrap=1 one cycle; further step bin=0xFE, gray=0x81, wrap=0.
- load=1, en=1, load_bin=0x2A -> bin=0x2A, gray=0x3F, wrap=0 (load priority); then en=0 for 3 cycles -> outputs hold.
- Full 512-cycle sweep up then down with random direction flips -> every step exactly one gray bit changes, gray==bin^(bin>>1) every cycle, wrap count equals boundary crossings.
- Reset asserted mid-count at bin=0x57 with load=1 and en=1 -> next cycle bin=0, gray=0, wrap=0.
